i2c_cmd_sequencer: RTL

Command sequencer that sits directly upstream of the I2C master core. It buffers single-register write and read commands in a small FIFO and launches them one at a time on the master's start/address/data/size inputs. It waits for the master's completion or error indication, optionally retries, and reports one result per command. Host logic only pushes commands; it never handles the master's start pulse timing.

---
 rtl/i2c_cmd_sequencer.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: buffers single-register I2C write/read commands in a small FIFO
// and launches them one at a time on an I2C master core's start/addr/data/size inputs,
// waits for completion, error or timeout, and reports one result per command.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o          host push handshake
//   cmd_addr_i, cmd_reg_i, cmd_wdata_i command fields (addr bit0 = 1 for read)
//   busy_o                             FIFO non-empty or command in flight
//   rsp_valid_o, rsp_rdata_o,
//   rsp_status_o                       one-cycle result (00 ok, 01 NACK, 10 timeout)
//   m_start_o, m_addr_o, m_data_o,
//   m_size_o                           to master
//   m_data_received_i, m_valid_trans_i,
//   m_valid_recep_i, m_error_i         from master
//
// Optional feature: define I2C_SEQ_RETRY_EN to retry failed attempts up to MAX_RETRY times.
module i2c_cmd_sequencer #(
  parameter int unsigned DATA_WIDTH     = 9,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [7:0]              cmd_addr_i,
  input  logic [7:0]              cmd_reg_i,
  input  logic [7:0]              cmd_wdata_i,
  output logic                    busy_o,
  output logic                    rsp_valid_o,
  output logic [7:0]              rsp_rdata_o,
  output logic [1:0]              rsp_status_o,
  output logic                    m_start_o,
  output logic [7:0]              m_addr_o,
  output logic [DATA_WIDTH*8-1:0] m_data_o,
  output logic [7:0]              m_size_o,
  input  logic [7:0]              m_data_received_i,
  input  logic                    m_valid_trans_i,
  input  logic                    m_valid_recep_i,
  input  logic                    m_error_i
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  if (DATA_WIDTH < 2) begin : g_bad_dw
    $error("DATA_WIDTH must be at least 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fd
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end
  if (TIMEOUT_CYCLES == 24'd0 || MAX_RETRY > 255) begin : g_bad_misc
    $error("TIMEOUT_CYCLES must be >= 1 and MAX_RETRY <= 255");
  end

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StGap} state_e;

  state_e state_q, state_d;

  // FIFO entries are {addr, reg, wdata}
  logic [23:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  logic [23:0]   work_q, work_d;
  logic [1:0]    status_q, status_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [23:0]   tmo_q, tmo_d;
  logic          gap_q, gap_d;
  logic          retry_due;
  logic          is_read;

  logic                    cmd_ready_q, cmd_ready_d;
  logic                    busy_q, busy_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [7:0]              rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_status_q, rsp_status_d;
  logic                    m_start_q, m_start_d;
  logic [7:0]              m_addr_q, m_addr_d;
  logic [DATA_WIDTH*8-1:0] m_data_q, m_data_d;
  logic [7:0]              m_size_q, m_size_d;

  assign push    = cmd_valid_i && cmd_ready_q;
  assign is_read = work_q[16];

`ifdef I2C_SEQ_RETRY_EN
  logic [7:0] retry_q;

  assign retry_due = (status_q != 2'b00) && (32'(retry_q) < MAX_RETRY);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retry_q <= '0;
    end else if (state_q == StIdle) begin
      retry_q <= '0;
    end else if (state_q == StGap && gap_q && retry_due) begin
      retry_q <= retry_q + 8'd1;
    end
  end
`else
  assign retry_due = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    status_d     = status_q;
    rdata_d      = rdata_q;
    tmo_d        = tmo_q;
    gap_d        = gap_q;
    pop          = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;
    m_start_d    = m_start_q;
    m_addr_d     = m_addr_q;
    m_data_d     = m_data_q;
    m_size_d     = m_size_q;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          work_d  = mem_q[rd_ptr_q];
          state_d = StLoad;
        end
      end
      StLoad: begin
        m_addr_d        = work_q[23:16];
        m_data_d        = '0;
        m_data_d[7:0]   = work_q[15:8];
        m_data_d[15:8]  = work_q[7:0];
        // Reads only send the register pointer; the master does the repeated-start read.
        m_size_d        = is_read ? 8'd1 : 8'd2;
        state_d         = StStart;
      end
      StStart: begin
        m_start_d = 1'b1;
        tmo_d     = '0;
        state_d   = StWait;
      end
      StWait: begin
        gap_d = 1'b0;
        if (m_error_i) begin
          status_d  = 2'b01;
          m_start_d = 1'b0;
          state_d   = StGap;
        end else if (is_read ? m_valid_recep_i : m_valid_trans_i) begin
          status_d  = 2'b00;
          rdata_d   = m_data_received_i;
          m_start_d = 1'b0;
          state_d   = StGap;
        end else if (tmo_q >= TIMEOUT_CYCLES - 24'd1) begin
          status_d  = 2'b10;
          m_start_d = 1'b0;
          state_d   = StGap;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      StGap: begin
        if (!gap_q) begin
          gap_d = 1'b1;
          // Result is registered now so it shows during the second gap cycle.
          if (!retry_due) begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = status_q;
            rsp_rdata_d  = (status_q == 2'b00 && is_read) ? rdata_q : 8'h00;
          end
        end else begin
          state_d = retry_due ? StStart : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
    cmd_ready_d = (count_d != (AW+1)'(FIFO_DEPTH));
    // Busy drops together with the response pulse when nothing else is queued.
    busy_d      = (count_d != '0) || ((state_d != StIdle) && !rsp_valid_d);
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_addr_i, cmd_reg_i, cmd_wdata_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      work_q       <= '0;
      status_q     <= '0;
      rdata_q      <= '0;
      tmo_q        <= '0;
      gap_q        <= 1'b0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= '0;
      m_start_q    <= 1'b0;
      m_addr_q     <= '0;
      m_data_q     <= '0;
      m_size_q     <= '0;
    end else begin
      state_q      <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q      <= count_d;
      work_q       <= work_d;
      status_q     <= status_d;
      rdata_q      <= rdata_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
      m_start_q    <= m_start_d;
      m_addr_q     <= m_addr_d;
      m_data_q     <= m_data_d;
      m_size_q     <= m_size_d;
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign busy_o       = busy_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign rsp_status_o = rsp_status_q;
  assign m_start_o    = m_start_q;
  assign m_addr_o     = m_addr_q;
  assign m_data_o     = m_data_q;
  assign m_size_o     = m_size_q;

endmodule
